// File: rtl/fifo_sync_v2.sv
// Synchronous single-clock FIFO with chip select, sticky overflow/underflow flags,
// programmable almost-full/almost-empty thresholds and optional first-word-fall-through.
module fifo_sync_v2 #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1,
    parameter int unsigned FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cs,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic                          clr_err,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_wr_req;
    logic w_rd_req;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_evt;
    logic w_udf_evt;
    logic w_clr;

    // Status decodes straight from the registered count.
    assign w_empty      = (r_count == CNT_W'(0));
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= CNT_W'(AE_THRESH));
    assign almost_full  = (r_count >= CNT_W'(AF_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A full FIFO still takes a write when a read frees the head slot in the same cycle.
    assign w_wr_req  = cs & wr_en;
    assign w_rd_req  = cs & rd_en;
    assign w_rd_acc  = w_rd_req & ~w_empty;
    assign w_wr_acc  = w_wr_req & (~w_full | w_rd_acc);
    assign w_ovf_evt = w_wr_req & ~w_wr_acc;
    assign w_udf_evt = w_rd_req & w_empty;
    assign w_clr     = cs & clr_err;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= CNT_W'(0);
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error event wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (w_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_evt) begin
                r_underflow <= 1'b1;
            end else if (w_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_mem[r_rd_ptr];
        end else begin : g_reg_rd
            logic [DATA_WIDTH-1:0] r_data_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_out <= DATA_WIDTH'(0);
                end else if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Directed bench for fifo_sync_v2: a registered-read instance checked through a read-data
// scoreboard plus direct flag checks, and a FWFT instance sharing the same stimulus.
module tb_fifo_sync_v2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs, wr_en, rd_en, clr_err;
    logic [31:0] data_in;

    logic [31:0] data_out, data_out_f;
    logic        empty, full, almost_empty, almost_full, overflow, underflow;
    logic        empty_f, full_f, almost_empty_f, almost_full_f, overflow_f, underflow_f;
    logic [3:0]  count, count_f;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic        mon_pend = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_v2 #(.FIFO_DEPTH(8), .DATA_WIDTH(32), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_v2 #(.FIFO_DEPTH(8), .DATA_WIDTH(32), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_dut_f (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(data_out_f), .empty(empty_f), .full(full_f),
        .almost_empty(almost_empty_f), .almost_full(almost_full_f), .count(count_f),
        .overflow(overflow_f), .underflow(underflow_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, then settle just after the rising edge.
    task automatic step(input logic c, input logic w, input logic r, input logic clr,
                        input logic [31:0] d);
        cs = c; wr_en = w; rd_en = r; clr_err = clr; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: a read accepted at an edge presents its word before the following falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pend = 1'b0;
        end else begin
            if (mon_pend) begin
                if (exp_q.size() == 0) begin
                    chk("rd_data_unexpected", data_out, 32'hDEAD_BEEF ^ data_out ^ 32'h1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("rd_data", data_out, mon_exp);
                end
            end
            mon_pend = cs & rd_en & ~empty;
        end
    end

    initial begin
        rst_n = 1'b0;
        cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 32'h0;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Basic ordering and count stepping.
        step(1, 1, 0, 0, 32'd1);   chk("b_cnt1", 32'(count), 32'd1);
        step(1, 1, 0, 0, 32'd10);  chk("b_cnt2", 32'(count), 32'd2);
        step(1, 1, 0, 0, 32'd100); chk("b_cnt3", 32'(count), 32'd3);
        exp_q.push_back(32'd1); exp_q.push_back(32'd10); exp_q.push_back(32'd100);
        step(1, 0, 1, 0, 32'd0);   chk("b_cnt4", 32'(count), 32'd2);
        step(1, 0, 1, 0, 32'd0);   chk("b_cnt5", 32'(count), 32'd1);
        step(1, 0, 1, 0, 32'd0);   chk("b_cnt6", 32'(count), 32'd0);
        chk("b_empty", 32'(empty), 32'd1);
        idle();
        chk("b_dout_last", data_out, 32'd100);

        // Overflow on the ninth write, underflow on the ninth read.
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 0, 0, 32'd1 << i);
            if (i == 7) begin
                chk("o_full8", 32'(full), 32'd1);
                chk("o_ovf_before", 32'(overflow), 32'd0);
            end
        end
        chk("o_ovf", 32'(overflow), 32'd1);
        chk("o_cnt", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'd1 << i);
            step(1, 0, 1, 0, 32'd0);
        end
        chk("o_udf_before", 32'(underflow), 32'd0);
        step(1, 0, 1, 0, 32'd0);
        chk("o_udf", 32'(underflow), 32'd1);
        chk("o_dout_hold", data_out, 32'd128);
        idle();

        // clr_err needs chip select.
        step(0, 0, 0, 1, 32'd0);
        chk("c_ovf_cs0", 32'(overflow), 32'd1);
        chk("c_udf_cs0", 32'(underflow), 32'd1);
        step(1, 0, 0, 1, 32'd0);
        chk("c_ovf_clr", 32'(overflow), 32'd0);
        chk("c_udf_clr", 32'(underflow), 32'd0);

        // Threshold crossings: almost_full at 6, almost_empty off at 2.
        for (int i = 1; i <= 6; i++) begin
            step(1, 1, 0, 0, 32'h30 + 32'(i));
            chk("t_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            chk("t_ae", 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
        end
        step(0, 1, 0, 0, 32'hFF);
        chk("t_cs0_cnt", 32'(count), 32'd6);
        for (int i = 1; i <= 6; i++) begin
            exp_q.push_back(32'h30 + 32'(i));
            step(1, 0, 1, 0, 32'd0);
        end
        idle();

        // Full with simultaneous write/read, then drain across the pointer wrap.
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h10 + 32'(i));
            step(1, 1, 1, 0, 32'hA0 + 32'(i));
            chk("f_cnt", 32'(count), 32'd8);
            chk("f_full", 32'(full), 32'd1);
        end
        chk("f_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h14 + 32'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 32'd0);
        idle();
        chk("f_dout_last", data_out, 32'hA3);

        // Write and read together while empty.
        step(1, 1, 1, 0, 32'h77);
        chk("e_cnt", 32'(count), 32'd1);
        chk("e_udf", 32'(underflow), 32'd1);
        chk("e_dout_hold", data_out, 32'hA3);
        step(1, 0, 0, 1, 32'd0);
        exp_q.push_back(32'h77);
        step(1, 0, 1, 0, 32'd0);
        idle();

        // FWFT head visible without a read.
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_q.delete();
        step(1, 1, 0, 0, 32'h55);
        chk("w_empty", 32'(empty_f), 32'd0);
        chk("w_dout", data_out_f, 32'h55);
        exp_q.push_back(32'h55);
        step(1, 0, 1, 0, 32'd0);
        chk("w_empty_pop", 32'(empty_f), 32'd1);
        idle();

        // Asynchronous reset with entries stored.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 32'h70 + 32'(i));
        chk("r_cnt5", 32'(count), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("r_cnt0", 32'(count), 32'd0);
        chk("r_empty", 32'(empty), 32'd1);
        chk("r_dout0", data_out, 32'd0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        step(1, 1, 0, 0, 32'd7);
        chk("r_cnt_after", 32'(count), 32'd1);
        exp_q.push_back(32'd7);
        step(1, 0, 1, 0, 32'd0);
        chk("r_dout7", data_out, 32'd7);
        idle();
        idle();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_v2.md
FIFO_SYNC_V2 -- requirements
Module: fifo_sync_v2

Interface
REQ-001 Parameters SHALL be:
- FIFO_DEPTH, default 8: number of entries, power of two, >= 2.
- DATA_WIDTH, default 32: width of each entry.
- AF_THRESH, default FIFO_DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..FIFO_DEPTH.
- AE_THRESH, default 1: almost_empty asserts when count <= AE_THRESH; legal range 0..FIFO_DEPTH-1.
- FWFT, default 0: 0 = registered-read mode; 1 = first-word-fall-through mode.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- cs, in, 1: chip select; qualifies wr_en, rd_en and clr_err.
- wr_en, in, 1: write request.
- rd_en, in, 1: read request.
- clr_err, in, 1: clears the sticky error flags.
- data_in, in, DATA_WIDTH: write data.
- data_out, out, DATA_WIDTH: read data.
- empty, out, 1: count == 0.
- full, out, 1: count == FIFO_DEPTH.
- almost_empty, out, 1: count <= AE_THRESH.
- almost_full, out, 1: count >= AF_THRESH.
- count, out, $clog2(FIFO_DEPTH)+1: current number of stored entries.
- overflow, out, 1: sticky; a write was dropped.
- underflow, out, 1: sticky; a read was dropped.

Function
REQ-003 Write accepted = cs & wr_en & (~full | read accepted in the same cycle); the accepted word is stored at wr_ptr, and wr_ptr advances by one modulo FIFO_DEPTH.
REQ-004 Read accepted = cs & rd_en & ~empty; rd_ptr advances by one modulo FIFO_DEPTH.
REQ-005 Read/write pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap from FIFO_DEPTH-1 to 0 with no gap.
REQ-006 count SHALL be a register updated at the rising edge:
- +1 on write only.
- -1 on read only.
- Unchanged on both or neither.
REQ-007 empty, full, almost_empty and almost_full SHALL decode combinationally from the registered count, so they change in the same cycle count changes.
REQ-008 FWFT=0: on an accepted read, data_out registers mem[rd_ptr] at that edge; otherwise data_out holds its value. Read latency is 1 cycle.
REQ-009 FWFT=1: data_out = mem[rd_ptr] combinationally, so the head word is visible whenever empty=0. rd_en acts as a pop; data_out is undefined-but-stable while empty=1.
REQ-010 Simultaneous write and read when full: both are accepted; the old head is read, the new word takes the freed slot, and count stays at FIFO_DEPTH.
REQ-011 Simultaneous write and read when empty: the write is accepted, the read is dropped and sets underflow, count becomes 1, and data_out (FWFT=0) holds.
REQ-012 cs & wr_en while full, with no accepted read: the write is dropped, memory and pointers are unchanged, and overflow is set at that edge.
REQ-013 cs & rd_en while empty: the read is dropped, pointers are unchanged, data_out holds (FWFT=0), and underflow is set at that edge.
REQ-014 overflow and underflow SHALL remain set until reset or an edge with cs & clr_err. If clr_err coincides with a new error event, the flag SHALL remain set.
REQ-015 cs=0 SHALL suppress all writes, reads, error setting and clearing; all state holds.
REQ-016 Memory contents SHALL NOT be reset. Only entries written since reset are ever presented as valid data.

Reset
REQ-017 rst_n low SHALL immediately, without waiting for a clock edge, force:
- wr_ptr=0, rd_ptr=0, count=0.
- data_out=0 (FWFT=0 only).
- empty=1, full=0, almost_empty=1, almost_full=0.
- overflow=0, underflow=0.
REQ-018 Reset asserted mid-operation SHALL discard all stored entries.
REQ-019 The first operation after reset SHALL be accepted at the first rising edge after rst_n deasserts.

Verification (DEPTH=8, WIDTH=32, AF_THRESH=6, AE_THRESH=1, FWFT=0 unless noted)
REQ-020 Write 1, 10, 100, then three reads -> data_out = 1, 10, 100, each valid one cycle after its rd_en edge. count steps 1,2,3,2,1,0; empty returns to 1.
REQ-021 Write 2**i for i=0..8 (nine writes), then nine reads:
- full=1 after the 8th write; the 9th write (256) is dropped and overflow=1.
- Reads return 1..128; the 9th read sets underflow=1 and data_out holds at 128.
REQ-022 Fill to 8, then hold wr_en=rd_en=1 for 4 cycles with data 0xA0..0xA3:
- count stays 8 and full stays 1.
- Outputs are the original first 4 entries; a subsequent drain returns the remaining 4 original entries, then 0xA0..0xA3 (pointer wrap check).
REQ-023 Threshold check:
- Count 0→6: almost_full asserts at count=6, almost_empty deasserts at count=2.
- Pulse clr_err with cs=0: no effect. Pulse with cs=1: overflow and underflow clear.
REQ-024 FWFT=1: write 0x55 -> data_out=0x55 in the cycle empty drops, with no rd_en. One pop -> empty=1.
REQ-025 Reset checks:
- Assert rst_n low mid-clock with 5 entries stored -> count=0 and empty=1 with no clock edge required.
- After release, a write 7 then read -> data_out=7.
